// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: ALU operator encoding, opcode constants and operand selects.
// Used by alu_decoder and alu_issue_stage.
package riscv_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_EQ   = 4'd10,
      ALU_NE   = 4'd11,
      ALU_LT   = 4'd12,
      ALU_GE   = 4'd13,
      ALU_LTU  = 4'd14,
      ALU_GEU  = 4'd15
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [1:0] {SEL_RS1, SEL_PC, SEL_ZERO} op_a_sel_e;
   typedef enum logic [1:0] {SEL_RS2, SEL_IMM, SEL_FOUR} op_b_sel_e;

   // Shared by OP and OP-IMM; alt selects SUB/SRA (funct7 bit 5).
   function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
      alu_op_e op;
      op = ALU_ADD;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I decode of one instruction word into ALU operator, operand selects,
// immediate and writeback/branch/illegal flags.
module alu_decoder
   import riscv_pkg::*;
(
   input  logic [31:0] instr,
   output alu_op_e     operator,
   output op_a_sel_e   sel_a,
   output op_b_sel_e   sel_b,
   output logic [31:0] imm,
   output logic        rd_we,
   output logic        branch,
   output logic        illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        rd_nonzero;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] imm_sh;

   assign opcode     = instr[6:0];
   assign funct3     = instr[14:12];
   assign funct7     = instr[31:25];
   assign rd_nonzero = (instr[11:7] != 5'd0);
   assign imm_i      = {{20{instr[31]}}, instr[31:20]};
   assign imm_u      = {instr[31:12], 12'b0};
   assign imm_sh     = {27'b0, instr[24:20]};

   always_comb begin
      operator = ALU_ADD;
      sel_a    = SEL_RS1;
      sel_b    = SEL_RS2;
      imm      = 32'd0;
      rd_we    = 1'b0;
      branch   = 1'b0;
      illegal  = 1'b0;

      case (opcode)
         OPC_OP: begin
            operator = arith_op(funct3, funct7[5]);
            rd_we    = rd_nonzero;
            illegal  = !((funct7 == 7'h00) ||
                         ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
         end
         OPC_OP_IMM: begin
            sel_b = SEL_IMM;
            rd_we = rd_nonzero;
            if (funct3 == 3'b001) begin
               operator = ALU_SLL;
               imm      = imm_sh;
               illegal  = (funct7 != 7'h00);
            end else if (funct3 == 3'b101) begin
               operator = funct7[5] ? ALU_SRA : ALU_SRL;
               imm      = imm_sh;
               illegal  = (funct7 != 7'h00) && (funct7 != 7'h20);
            end else begin
               operator = arith_op(funct3, 1'b0);
               imm      = imm_i;
            end
         end
         OPC_LUI: begin
            sel_a = SEL_ZERO;
            sel_b = SEL_IMM;
            imm   = imm_u;
            rd_we = rd_nonzero;
         end
         OPC_AUIPC: begin
            sel_a = SEL_PC;
            sel_b = SEL_IMM;
            imm   = imm_u;
            rd_we = rd_nonzero;
         end
         OPC_JAL, OPC_JALR: begin
            sel_a = SEL_PC;
            sel_b = SEL_FOUR;
            rd_we = rd_nonzero;
         end
         OPC_BRANCH: begin
            branch = 1'b1;
            case (funct3)
               3'b000:  operator = ALU_EQ;
               3'b001:  operator = ALU_NE;
               3'b100:  operator = ALU_LT;
               3'b101:  operator = ALU_GE;
               3'b110:  operator = ALU_LTU;
               3'b111:  operator = ALU_GEU;
               default: illegal  = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase

      // Illegal instructions must never write back or redirect.
      if (illegal) begin
         operator = ALU_ADD;
         rd_we    = 1'b0;
         branch   = 1'b0;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register feeding the ALU, with valid/ready handshake and flush.
// Define ALU_ISSUE_FWD_EN to bypass same-cycle writeback data onto rs1/rs2.
module alu_issue_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   output logic        id_ready,
   input  logic [31:0] id_instr,
   input  logic [31:0] id_pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        flush,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        ex_valid,
   input  logic        ex_ready,
   output alu_op_e     ex_operator,
   output logic [31:0] ex_operand_a,
   output logic [31:0] ex_operand_b,
   output logic [4:0]  ex_rd,
   output logic        ex_rd_we,
   output logic        ex_branch,
   output logic        ex_illegal,
   output logic [31:0] ex_pc
);

   alu_op_e     dec_operator;
   op_a_sel_e   sel_a;
   op_b_sel_e   sel_b;
   logic [31:0] imm;
   logic        dec_rd_we;
   logic        dec_branch;
   logic        dec_illegal;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        load;

   alu_decoder u_decoder (
      .instr    (id_instr),
      .operator (dec_operator),
      .sel_a    (sel_a),
      .sel_b    (sel_b),
      .imm      (imm),
      .rd_we    (dec_rd_we),
      .branch   (dec_branch),
      .illegal  (dec_illegal)
   );

`ifdef ALU_ISSUE_FWD_EN
   assign rs1_val = (wb_we && (wb_rd != 5'd0) && (wb_rd == id_instr[19:15])) ? wb_data : rs1_data;
   assign rs2_val = (wb_we && (wb_rd != 5'd0) && (wb_rd == id_instr[24:20])) ? wb_data : rs2_data;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_we, wb_rd, wb_data};
   assign rs1_val   = rs1_data;
   assign rs2_val   = rs2_data;
`endif

   always_comb begin
      operand_a = rs1_val;
      case (sel_a)
         SEL_PC:   operand_a = id_pc;
         SEL_ZERO: operand_a = 32'd0;
         default:  operand_a = rs1_val;
      endcase
      operand_b = rs2_val;
      case (sel_b)
         SEL_IMM:  operand_b = imm;
         SEL_FOUR: operand_b = 32'd4;
         default:  operand_b = rs2_val;
      endcase
   end

   assign id_ready = ~ex_valid | ex_ready;
   assign load     = id_valid & id_ready & ~flush;

   // Payload only changes on load, so it stays stable while EX stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid     <= 1'b0;
         ex_operator  <= ALU_ADD;
         ex_operand_a <= 32'd0;
         ex_operand_b <= 32'd0;
         ex_rd        <= 5'd0;
         ex_rd_we     <= 1'b0;
         ex_branch    <= 1'b0;
         ex_illegal   <= 1'b0;
         ex_pc        <= RESET_PC;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (load) begin
         ex_valid     <= 1'b1;
         ex_operator  <= dec_operator;
         ex_operand_a <= operand_a;
         ex_operand_b <= operand_b;
         ex_rd        <= id_instr[11:7];
         ex_rd_we     <= dec_rd_we;
         ex_branch    <= dec_branch;
         ex_illegal   <= dec_illegal;
         ex_pc        <= id_pc;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage; honours ALU_ISSUE_FWD_EN when defined.
module tb_alu_issue_stage;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic        id_ready;
   logic [31:0] id_instr = 32'd0;
   logic [31:0] id_pc = 32'd0;
   logic [31:0] rs1_data = 32'd0;
   logic [31:0] rs2_data = 32'd0;
   logic        flush = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic [31:0] wb_data = 32'd0;
   logic        ex_valid;
   logic        ex_ready = 1'b1;
   alu_op_e     ex_operator;
   logic [31:0] ex_operand_a;
   logic [31:0] ex_operand_b;
   logic [4:0]  ex_rd;
   logic        ex_rd_we;
   logic        ex_branch;
   logic        ex_illegal;
   logic [31:0] ex_pc;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        rd_we;
      logic        branch;
      logic        illegal;
      logic [31:0] pc;
      logic        chk_ops;
   } exp_t;

   exp_t  sb[$];
   string sb_tag[$];
   int    n_compared = 0;
   int    n_mismatched = 0;

   alu_issue_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_ready     (id_ready),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .flush        (flush),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_operator  (ex_operator),
      .ex_operand_a (ex_operand_a),
      .ex_operand_b (ex_operand_b),
      .ex_rd        (ex_rd),
      .ex_rd_we     (ex_rd_we),
      .ex_branch    (ex_branch),
      .ex_illegal   (ex_illegal),
      .ex_pc        (ex_pc)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs on the falling edge, then lets combinational paths settle.
   task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic ready, input logic fl);
      @(negedge clk);
      id_valid = valid;
      id_instr = instr;
      id_pc    = pc;
      rs1_data = r1;
      rs2_data = r2;
      ex_ready = ready;
      flush    = fl;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic rd_we, input logic br,
                          input logic ill, input logic [31:0] pc, input logic chk_ops,
                          input string tag);
      exp_t e;
      e.op      = op;
      e.a       = a;
      e.b       = b;
      e.rd      = rd;
      e.rd_we   = rd_we;
      e.branch  = br;
      e.illegal = ill;
      e.pc      = pc;
      e.chk_ops = chk_ops;
      sb.push_back(e);
      sb_tag.push_back(tag);
   endtask

   task automatic dropExp();
      if (sb.size() != 0) begin
         void'(sb.pop_front());
         void'(sb_tag.pop_front());
      end
   endtask

   task automatic checkOutput(input bit do_pop);
      exp_t  e;
      string t;
      cmp("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() == 0) return;
      e = sb[0];
      t = sb_tag[0];
      cmp({t, ".valid"},   32'(ex_valid),    32'd1);
      cmp({t, ".op"},      32'(ex_operator), 32'(e.op));
      if (e.chk_ops) begin
         cmp({t, ".a"},  ex_operand_a, e.a);
         cmp({t, ".b"},  ex_operand_b, e.b);
         cmp({t, ".rd"}, 32'(ex_rd),   32'(e.rd));
      end
      cmp({t, ".rd_we"},   32'(ex_rd_we),    32'(e.rd_we));
      cmp({t, ".branch"},  32'(ex_branch),   32'(e.branch));
      cmp({t, ".illegal"}, 32'(ex_illegal),  32'(e.illegal));
      cmp({t, ".pc"},      ex_pc,            e.pc);
      if (do_pop) dropExp();
   endtask

   task automatic checkReset(input string t);
      cmp({t, ".valid"},   32'(ex_valid),     32'd0);
      cmp({t, ".op"},      32'(ex_operator),  32'(ALU_ADD));
      cmp({t, ".a"},       ex_operand_a,      32'd0);
      cmp({t, ".b"},       ex_operand_b,      32'd0);
      cmp({t, ".rd"},      32'(ex_rd),        32'd0);
      cmp({t, ".rd_we"},   32'(ex_rd_we),     32'd0);
      cmp({t, ".branch"},  32'(ex_branch),    32'd0);
      cmp({t, ".illegal"}, 32'(ex_illegal),   32'd0);
      cmp({t, ".pc"},      ex_pc,             32'd0);
   endtask

   initial begin
      logic [31:0] fwd_exp;

      $display("[TB] start");
      step();
      step();
      checkReset("reset");
      cmp("reset.id_ready", 32'(id_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // addi x1,x2,-1
      applyStimulus(1'b1, 32'hFFF10093, 32'h100, 32'd5, 32'd0, 1'b1, 1'b0);
      pushExp(ALU_ADD, 32'd5, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, "addi");
      step();
      checkOutput(1'b1);
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step();
      cmp("idle.valid", 32'(ex_valid), 32'd0);

      // sub x3,x4,x5 held by EX for three cycles while xor waits upstream
      applyStimulus(1'b1, 32'h405201B3, 32'h104, 32'd10, 32'd3, 1'b0, 1'b0);
      pushExp(ALU_SUB, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0, 32'h104, 1'b1, "sub");
      step();
      checkOutput(1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h0083C333, 32'h108, 32'h77, 32'h88, 1'b0, 1'b0);
         cmp("stall.id_ready", 32'(id_ready), 32'd0);
         step();
         checkOutput(1'b0);
      end
      applyStimulus(1'b1, 32'h0083C333, 32'h108, 32'h77, 32'h88, 1'b1, 1'b0);
      cmp("release.id_ready", 32'(id_ready), 32'd1);
      pushExp(ALU_XOR, 32'h77, 32'h88, 5'd6, 1'b1, 1'b0, 1'b0, 32'h108, 1'b1, "xor");
      step();
      dropExp();
      checkOutput(1'b1);

      // Back-to-back stream at full throughput
      applyStimulus(1'b1, 32'h0020C063, 32'h10C, 32'h11, 32'h22, 1'b1, 1'b0);
      pushExp(ALU_LT, 32'h11, 32'h22, 5'd0, 1'b0, 1'b1, 1'b0, 32'h10C, 1'b1, "blt");
      step();
      checkOutput(1'b1);
      applyStimulus(1'b1, 32'h0020A063, 32'h110, 32'h11, 32'h22, 1'b1, 1'b0);
      pushExp(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h110, 1'b0, "br010");
      step();
      checkOutput(1'b1);
      applyStimulus(1'b1, 32'h12345397, 32'h80, 32'h55, 32'h66, 1'b1, 1'b0);
      pushExp(ALU_ADD, 32'h80, 32'h12345000, 5'd7, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, "auipc");
      step();
      checkOutput(1'b1);
      applyStimulus(1'b1, 32'hABCDE037, 32'h84, 32'h55, 32'h66, 1'b1, 1'b0);
      pushExp(ALU_ADD, 32'd0, 32'hABCDE000, 5'd0, 1'b0, 1'b0, 1'b0, 32'h84, 1'b1, "lui_x0");
      step();
      checkOutput(1'b1);
      applyStimulus(1'b1, 32'h000000EF, 32'hFFFF_FFFC, 32'h55, 32'h66, 1'b1, 1'b0);
      pushExp(ALU_ADD, 32'hFFFF_FFFC, 32'd4, 5'd1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, "jal");
      step();
      checkOutput(1'b1);
      applyStimulus(1'b1, 32'h40335293, 32'h88, 32'h8000_0000, 32'h66, 1'b1, 1'b0);
      pushExp(ALU_SRA, 32'h8000_0000, 32'd3, 5'd5, 1'b1, 1'b0, 1'b0, 32'h88, 1'b1, "srai");
      step();
      checkOutput(1'b1);
      applyStimulus(1'b1, 32'h40331293, 32'h8C, 32'h8000_0000, 32'h66, 1'b1, 1'b0);
      pushExp(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h8C, 1'b0, "slli_bad");
      step();
      checkOutput(1'b1);
      applyStimulus(1'b1, 32'h0000007F, 32'h90, 32'h1, 32'h2, 1'b1, 1'b0);
      pushExp(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h90, 1'b0, "bad_opc");
      step();
      checkOutput(1'b1);
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step();

      // Flush kills a stalled payload and the instruction offered alongside it
      applyStimulus(1'b1, 32'h003100B3, 32'h200, 32'd1, 32'd2, 1'b0, 1'b0);
      pushExp(ALU_ADD, 32'd1, 32'd2, 5'd1, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, "add_pre_flush");
      step();
      checkOutput(1'b0);
      applyStimulus(1'b1, 32'hFFF10093, 32'h204, 32'd5, 32'd0, 1'b0, 1'b1);
      step();
      dropExp();
      cmp("flush.valid", 32'(ex_valid), 32'd0);
      applyStimulus(1'b1, 32'hFFF10093, 32'h208, 32'd5, 32'd0, 1'b1, 1'b1);
      step();
      cmp("flush_beats_load.valid", 32'(ex_valid), 32'd0);

      // Writeback bypass onto both sources, then wb_rd==x0 which must never forward
      wb_we   = 1'b1;
      wb_rd   = 5'd2;
      wb_data = 32'h0000_DEAD;
`ifdef ALU_ISSUE_FWD_EN
      fwd_exp = 32'h0000_DEAD;
`else
      fwd_exp = 32'd0;
`endif
      applyStimulus(1'b1, 32'h002100B3, 32'h300, 32'd0, 32'd0, 1'b1, 1'b0);
      pushExp(ALU_ADD, fwd_exp, fwd_exp, 5'd1, 1'b1, 1'b0, 1'b0, 32'h300, 1'b1, "fwd_x2");
      step();
      checkOutput(1'b1);
      wb_rd   = 5'd0;
      applyStimulus(1'b1, 32'h000000B3, 32'h304, 32'h11, 32'h22, 1'b1, 1'b0);
      pushExp(ALU_ADD, 32'h11, 32'h22, 5'd1, 1'b1, 1'b0, 1'b0, 32'h304, 1'b1, "fwd_x0");
      step();
      checkOutput(1'b1);
      wb_we   = 1'b0;
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      step();

      // Reset while a payload is stalled
      applyStimulus(1'b1, 32'h405201B3, 32'h400, 32'd9, 32'd4, 1'b0, 1'b0);
      pushExp(ALU_SUB, 32'd9, 32'd4, 5'd3, 1'b1, 1'b0, 1'b0, 32'h400, 1'b1, "sub_pre_reset");
      step();
      checkOutput(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      step();
      dropExp();
      checkReset("mid_reset");
      @(negedge clk);
      rst_n    = 1'b1;
      id_valid = 1'b0;
      ex_ready = 1'b1;

      cmp("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
